bp_update_queue: RTL and testbench

Buffers resolved-branch outcomes from the execute stage and drains them, one per cycle, into the branch predictor's update port (update / updatePc / reality). It decouples branch resolution timing from predictor-table write availability and flags mispredictions at enqueue time. It sits between EX/MEM branch resolution and the GShare predictor.

---
 rtl/bp_update_queue_if.sv | 48 ++++
 rtl/bp_update_queue.sv | 113 +++++++++++
 tb/tb_bp_update_queue.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Handshake and update bus between branch resolution, the update queue and the predictor.
// Latency: none, this is wiring only.
// Backpressure: in_ready from the queue; upd_allow from the predictor. BPQ_STATS_EN adds stat ports.
interface bp_update_queue_if #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_pc;
    logic                 in_taken;
    logic                 in_pred;
    logic                 upd_allow;
    logic                 update;
    logic [BIT_WIDTH-1:0] updatePc;
    logic                 reality;
    logic                 mispredict;
    logic [BIT_WIDTH-1:0] mispredict_pc;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
`ifdef BPQ_STATS_EN
    logic [15:0]          stat_updates;
    logic [15:0]          stat_mispredicts;
`endif

    // Producer / predictor side.
    modport master (
        output in_valid, in_pc, in_taken, in_pred, upd_allow,
        input  in_ready, update, updatePc, reality, mispredict, mispredict_pc,
               count, full, empty
`ifdef BPQ_STATS_EN
        , input stat_updates, stat_mispredicts
`endif
    );

    // Queue side.
    modport slave (
        input  in_valid, in_pc, in_taken, in_pred, upd_allow,
        output in_ready, update, updatePc, reality, mispredict, mispredict_pc,
               count, full, empty
`ifdef BPQ_STATS_EN
        , output stat_updates, stat_mispredicts
`endif
    );
endinterface

// File: rtl/bp_update_queue.sv
// Circular FIFO of resolved branches drained one per cycle into the predictor update port.
// Latency: push at edge N into an empty queue gives update high after edge N+1 (2 cycles).
// Backpressure: in_ready = !full from registers; pops only when upd_allow && !empty.
// Optional BPQ_STATS_EN: saturating 16-bit pop and mispredict counters.
module bp_update_queue #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input logic          clk,
    input logic          reset,
    bp_update_queue_if.slave bq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Each entry is {pc, taken}.
    logic [BIT_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CW-1:0]        count_q;
    logic                 update_q;
    logic [BIT_WIDTH-1:0] upd_pc_q;
    logic                 reality_q;
    logic                 mis_q;
    logic [BIT_WIDTH-1:0] mis_pc_q;
    logic                 full_w;
    logic                 empty_w;
    logic                 push;
    logic                 pop;

    // Status depends on count only, so there is no path from in_valid/upd_allow.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign push    = bq.in_valid && !full_w;
    assign pop     = bq.upd_allow && !empty_w;

    assign bq.in_ready      = !full_w;
    assign bq.full          = full_w;
    assign bq.empty         = empty_w;
    assign bq.count         = count_q;
    assign bq.update        = update_q;
    assign bq.updatePc      = upd_pc_q;
    assign bq.reality       = reality_q;
    assign bq.mispredict    = mis_q;
    assign bq.mispredict_pc = mis_pc_q;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bq.in_pc, bq.in_taken};
        end
    end

    // Pointers, occupancy and the registered update/mispredict outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            update_q  <= 1'b0;
            upd_pc_q  <= '0;
            reality_q <= 1'b0;
            mis_q     <= 1'b0;
            mis_pc_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                upd_pc_q  <= mem[rd_ptr][BIT_WIDTH:1];
                reality_q <= mem[rd_ptr][0];
            end
            update_q <= pop;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            // Mispredict is judged on accepted pushes only.
            if (push && (bq.in_taken != bq.in_pred)) begin
                mis_q    <= 1'b1;
                mis_pc_q <= bq.in_pc;
            end else begin
                mis_q <= 1'b0;
            end
        end
    end

`ifdef BPQ_STATS_EN
    logic [15:0] stat_upd_q;
    logic [15:0] stat_mis_q;

    assign bq.stat_updates     = stat_upd_q;
    assign bq.stat_mispredicts = stat_mis_q;

    // Saturating event counters for pops and mispredict pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && (stat_upd_q != 16'hFFFF)) begin
                stat_upd_q <= stat_upd_q + 16'd1;
            end
            if (push && (bq.in_taken != bq.in_pred) && (stat_mis_q != 16'hFFFF)) begin
                stat_mis_q <= stat_mis_q + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed steps then random traffic vs a queue model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Stat counters are checked only when BPQ_STATS_EN is defined.
module tb_bp_update_queue;
    localparam int BW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [BW-1:0] pc;
        logic          taken;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ent_t          q[$];
    logic          exp_update;
    logic [BW-1:0] exp_upc;
    logic          exp_real;
    logic          exp_mis;
    logic [BW-1:0] exp_mpc;
    int            exp_stat_upd;
    int            exp_stat_mis;

    bp_update_queue_if #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) bq ();

    bp_update_queue #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bq    (bq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("count",         32'(bq.count), 32'(q.size()));
        check("update",        32'(bq.update), 32'(exp_update));
        check("updatePc",      bq.updatePc, exp_upc);
        check("reality",       32'(bq.reality), 32'(exp_real));
        check("mispredict",    32'(bq.mispredict), 32'(exp_mis));
        check("mispredict_pc", bq.mispredict_pc, exp_mpc);
`ifdef BPQ_STATS_EN
        check("stat_updates",     32'(bq.stat_updates), 32'(exp_stat_upd));
        check("stat_mispredicts", 32'(bq.stat_mispredicts), 32'(exp_stat_mis));
`endif
    endtask

    // One clock: drive inputs, check status flags, clock, update model, check outputs.
    task automatic step(input logic v, input logic [BW-1:0] pc, input logic t,
                        input logic p, input logic a);
        bit do_push;
        bit do_pop;
        ent_t e;
        bq.in_valid  = v;
        bq.in_pc     = pc;
        bq.in_taken  = t;
        bq.in_pred   = p;
        bq.upd_allow = a;
        check("in_ready", 32'(bq.in_ready), 32'(q.size() < DEPTH));
        check("full",     32'(bq.full),     32'(q.size() == DEPTH));
        check("empty",    32'(bq.empty),    32'(q.size() == 0));
        do_push = v && (q.size() < DEPTH);
        do_pop  = a && (q.size() > 0);
        @(posedge clk);
        #1;
        exp_update = do_pop;
        if (do_pop) begin
            e = q.pop_front();
            exp_upc  = e.pc;
            exp_real = e.taken;
            if (exp_stat_upd < 16'hFFFF) exp_stat_upd++;
        end
        if (do_push) begin
            e.pc = pc;
            e.taken = t;
            q.push_back(e);
        end
        exp_mis = do_push && (t != p);
        if (exp_mis) begin
            exp_mpc = pc;
            if (exp_stat_mis < 16'hFFFF) exp_stat_mis++;
        end
        check_outputs();
    endtask

    task automatic do_reset(input logic v, input logic a);
        reset        = 1'b1;
        bq.in_valid  = v;
        bq.in_pc     = 32'hDEAD0000;
        bq.in_taken  = 1'b1;
        bq.in_pred   = 1'b0;
        bq.upd_allow = a;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_update   = 1'b0;
        exp_upc      = '0;
        exp_real     = 1'b0;
        exp_mis      = 1'b0;
        exp_mpc      = '0;
        exp_stat_upd = 0;
        exp_stat_mis = 0;
        check_outputs();
    endtask

    initial begin
        logic [3:0] tk;
        int pushed;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bq.in_valid  = 1'b0;
        bq.in_pc     = '0;
        bq.in_taken  = 1'b0;
        bq.in_pred   = 1'b0;
        bq.upd_allow = 1'b0;

        // Reset and idle.
        do_reset(1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Fill with upd_allow low, then a refused fifth request.
        tk = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), tk[i], tk[i], 1'b0);
        end
        step(1'b1, 32'h110, 1'b1, 1'b1, 1'b0);
        check("full_after_fill", 32'(bq.full), 32'd1);
        // Drain: four consecutive updates 0x100..0x10C with reality 1,0,1,1.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            check("drain_pc", bq.updatePc, 32'h100 + 32'(4 * i));
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Mispredict pulse, then no pulse on a matching push.
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        check("mis_pulse_pc", bq.mispredict_pc, 32'h200);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        // Count 2: push and pop on one edge keeps count, update carries the older entry.
        step(1'b1, 32'h208, 1'b1, 1'b1, 1'b1);
        check("simul_count", 32'(bq.count), 32'd2);
        check("simul_pc", bq.updatePc, 32'h200);
        step(1'b1, 32'h20C, 1'b0, 1'b1, 1'b0);

        // Reset with three entries queued and traffic present.
        do_reset(1'b1, 1'b1);
        step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Ten entries through the queue with upd_allow toggling.
        do_reset(1'b0, 1'b0);
        pushed = 0;
        for (int i = 0; i < 60; i++) begin
            if (pushed == 10 && q.size() == 0) break;
            if (pushed < 10) begin
                if (q.size() < DEPTH) begin
                    step(1'b1, 32'h400 + 32'(4 * pushed), pushed[0], 1'b0, (i % 2) == 0);
                    pushed++;
                end else begin
                    step(1'b1, 32'h400 + 32'(4 * pushed), pushed[0], 1'b0, (i % 2) == 0);
                end
            end else begin
                step(1'b0, 32'h0, 1'b0, 1'b0, (i % 2) == 0);
            end
        end
        check("wrap_drained", 32'(q.size()), 32'd0);
`ifdef BPQ_STATS_EN
        check("wrap_stat_updates", 32'(bq.stat_updates), 32'd10);
`endif

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
